// File: rtl/bypass_ctr_et.sv
// bypass_ctr_et: masked up-counter with start/busy/done run control and early termination.
// Bypassed bit positions are forced to 1 before the increment so the carry skips them.
module bypass_ctr_et #(
    parameter int WIDTH     = 8,
    parameter int AUTO_STOP = 1,
    parameter int REVERSE   = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] bp,
    input  logic             en,
    input  logic             halt,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] cnt,
    output logic             ovf,
    output logic [WIDTH:0]   steps
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t           state_q;
    logic [WIDTH-1:0] mask_q, cnt_q, cnt_d;
    logic [WIDTH:0]   steps_q, steps_d, sum;
    logic             busy_q, done_q, ovf_q, wrap;
    always_comb begin
        sum     = {1'b0, cnt_q | mask_q} + (WIDTH+1)'(1);
        cnt_d   = sum[WIDTH-1:0] & ~mask_q;
        wrap    = sum[WIDTH];
        steps_d = &steps_q ? steps_q : steps_q + 1'b1;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            mask_q  <= '0;
            cnt_q   <= '0;
            steps_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE, DONE: begin
                    ovf_q <= 1'b0;
                    if (start) begin
                        state_q <= RUN;
                        mask_q  <= bp;
                        cnt_q   <= '0;
                        steps_q <= '0;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                    end
                end
                RUN: begin
                    if (halt) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        ovf_q   <= 1'b0;
                    end else if (en) begin
                        cnt_q   <= cnt_d;
                        steps_q <= steps_d;
                        ovf_q   <= wrap;
                        if (wrap && AUTO_STOP != 0) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end else begin
                        ovf_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    // Bit reversal is a pure output remap; counting stays in natural order.
    for (genvar i = 0; i < WIDTH; i++) begin : g_out
        assign cnt[i] = (REVERSE != 0) ? cnt_q[WIDTH-1-i] : cnt_q[i];
    end
    assign busy  = busy_q;
    assign done  = done_q;
    assign ovf   = ovf_q;
    assign steps = steps_q;
endmodule

// File: tb/tb_bypass_ctr_et.sv
// tb_bypass_ctr_et: table-driven checks of the auto-stop instance plus directed
// sequences for the reversed free-running instance and asynchronous reset.
module tb_bypass_ctr_et;
    logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0, en = 1'b0, halt = 1'b0;
    logic [3:0] bp = 4'b0;
    logic       busy1, done1, ovf1, busy2, done2, ovf2;
    logic [3:0] cnt1, cnt2;
    logic [4:0] steps1, steps2;
    int         checks = 0, errors = 0;

    bypass_ctr_et #(.WIDTH(4), .AUTO_STOP(1), .REVERSE(0)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .bp(bp), .en(en), .halt(halt),
        .busy(busy1), .done(done1), .cnt(cnt1), .ovf(ovf1), .steps(steps1));
    bypass_ctr_et #(.WIDTH(4), .AUTO_STOP(0), .REVERSE(1)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start), .bp(bp), .en(en), .halt(halt),
        .busy(busy2), .done(done2), .cnt(cnt2), .ovf(ovf2), .steps(steps2));

    always #5 clk = ~clk;

    typedef struct {
        logic       start, en, halt;
        logic [3:0] bp, cnt;
        logic       ovf, busy, done;
        logic [4:0] steps;
    } vec_t;
    vec_t tbl[$];

    function automatic void add(logic s, logic e, logic h, logic [3:0] b, logic [3:0] c,
                                logic o, logic bz, logic d, logic [4:0] st);
        vec_t v;
        v.start = s; v.en = e; v.halt = h; v.bp = b; v.cnt = c;
        v.ovf = o; v.busy = bz; v.done = d; v.steps = st;
        tbl.push_back(v);
    endfunction

    task automatic check(string name, logic [11:0] act, logic [11:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got cnt/ovf/busy/done/steps=%b_%b_%b_%b_%b want %b_%b_%b_%b_%b", name,
                     act[11:8], act[7], act[6], act[5], act[4:0],
                     exp[11:8], exp[7], exp[6], exp[5], exp[4:0]);
        end
    endtask

    task automatic cycle(logic s, logic e, logic h, logic [3:0] b);
        start = s; en = e; halt = h; bp = b;
        @(posedge clk);
        @(negedge clk);
    endtask

    logic [3:0] rev [16] = '{4'h0, 4'h8, 4'h4, 4'hC, 4'h2, 4'hA, 4'h6, 4'hE,
                             4'h1, 4'h9, 4'h5, 4'hD, 4'h3, 4'hB, 4'h7, 4'hF};

    initial begin
        // full period, mask 0000
        add(1, 0, 0, 4'b0000, 4'd0, 0, 1, 0, 5'd0);
        for (int i = 1; i <= 16; i++)
            add(0, 1, 0, 4'b0000, 4'(i % 16), i == 16, i < 16, i == 16, 5'(i));
        add(0, 1, 0, 4'b0000, 4'd0, 0, 0, 1, 5'd16);
        // partial mask 0101; a start mid-run (with a new bp) must be ignored
        add(1, 0, 0, 4'b0101, 4'b0000, 0, 1, 0, 5'd0);
        add(0, 1, 0, 4'b0000, 4'b0010, 0, 1, 0, 5'd1);
        add(1, 1, 0, 4'b0000, 4'b1000, 0, 1, 0, 5'd2);
        add(0, 0, 0, 4'b0000, 4'b1000, 0, 1, 0, 5'd2);
        add(0, 1, 0, 4'b0000, 4'b1010, 0, 1, 0, 5'd3);
        add(0, 1, 0, 4'b0000, 4'b0000, 1, 0, 1, 5'd4);
        // all bits bypassed; start together with en in DONE takes only the start
        add(1, 1, 0, 4'b1111, 4'b0000, 0, 1, 0, 5'd0);
        add(0, 1, 0, 4'b0000, 4'b0000, 1, 0, 1, 5'd1);
        add(0, 0, 0, 4'b0000, 4'b0000, 0, 0, 1, 5'd1);
        // early halt after 5 steps with gaps; halt+en+start together
        add(1, 0, 0, 4'b0000, 4'd0, 0, 1, 0, 5'd0);
        add(0, 1, 0, 4'b0000, 4'd1, 0, 1, 0, 5'd1);
        add(0, 1, 0, 4'b0000, 4'd2, 0, 1, 0, 5'd2);
        add(0, 0, 0, 4'b0000, 4'd2, 0, 1, 0, 5'd2);
        add(0, 1, 0, 4'b0000, 4'd3, 0, 1, 0, 5'd3);
        add(0, 1, 0, 4'b0000, 4'd4, 0, 1, 0, 5'd4);
        add(0, 1, 0, 4'b0000, 4'd5, 0, 1, 0, 5'd5);
        add(1, 1, 1, 4'b1111, 4'd5, 0, 0, 1, 5'd5);
        add(0, 1, 0, 4'b0000, 4'd5, 0, 0, 1, 5'd5);

        #1;
        check("reset1", {cnt1, ovf1, busy1, done1, steps1}, 12'd0);
        check("reset2", {cnt2, ovf2, busy2, done2, steps2}, 12'd0);
        @(negedge clk);
        rst_n = 1'b1;
        foreach (tbl[k]) begin
            cycle(tbl[k].start, tbl[k].en, tbl[k].halt, tbl[k].bp);
            check($sformatf("vec%0d", k), {cnt1, ovf1, busy1, done1, steps1},
                  {tbl[k].cnt, tbl[k].ovf, tbl[k].busy, tbl[k].done, tbl[k].steps});
        end

        // reversed free-running instance: fresh reset, then 17 steps through a wrap
        rst_n = 1'b0;
        #1;
        check("reset2_mid", {cnt2, ovf2, busy2, done2, steps2}, 12'd0);
        rst_n = 1'b1;
        cycle(1, 0, 0, 4'b0000);
        check("rev_start", {cnt2, ovf2, busy2, done2, steps2}, {4'd0, 1'b0, 1'b1, 1'b0, 5'd0});
        for (int i = 1; i <= 17; i++) begin
            cycle(0, 1, 0, 4'b0000);
            check($sformatf("rev_step%0d", i), {cnt2, ovf2, busy2, done2, steps2},
                  {rev[i % 16], i == 16, 1'b1, 1'b0, 5'(i)});
        end
        // asynchronous reset mid-run: outputs clear before the next rising edge
        #1 rst_n = 1'b0;
        #1;
        check("async_rst1", {cnt1, ovf1, busy1, done1, steps1}, 12'd0);
        check("async_rst2", {cnt2, ovf2, busy2, done2, steps2}, 12'd0);
        @(negedge clk);
        rst_n = 1'b1;
        // steps saturation with AUTO_STOP=0
        cycle(1, 0, 0, 4'b0000);
        for (int i = 1; i <= 40; i++) begin
            cycle(0, 1, 0, 4'b0000);
            if (i == 31 || i == 40)
                check($sformatf("sat_step%0d", i), {cnt2, ovf2, busy2, done2, steps2},
                      {rev[i % 16], 1'b0, 1'b1, 1'b0, 5'd31});
        end
        cycle(0, 1, 1, 4'b0000);
        check("rev_halt", {cnt2, ovf2, busy2, done2, steps2}, {rev[8], 1'b0, 1'b0, 1'b1, 5'd31});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/bypass_ctr_et.md
# bypass_ctr_et

Parametrised successor to the bypass counter. It is an up-counter whose bypassed bit positions are skipped: it walks only the 2^(WIDTH−popcount(mask)) codes built from the active bits, which gives reduced-precision stochastic-computing bitstream generation. It adds a start/busy/done run controller, step enable, and early termination, either external or on full period. An optional bit-reversed output provides van der Corput style sequences. It sits between the precision/early-termination controller and the SC comparator/SNG stage.

## Interface
- WIDTH, 8: counter width in bits (≥2).
- AUTO_STOP, 1: 1 = run ends automatically on the wrap step; 0 = run continues until halt.
- REVERSE, 0: 1 = `cnt` is presented bit-reversed (bit i of the output = internal bit WIDTH−1−i); 0 = natural order.
- clk, input, 1: the single clock; all state changes on its rising edge.
- rst_n, input, 1: reset, asynchronous and active-low.
- start, input, 1: begin a run; accepted only in IDLE or DONE.
- bp, input, WIDTH: bypass mask; sampled only when start is accepted. 1 = bit position skipped.
- en, input, 1: step enable while a run is active.
- halt, input, 1: early-termination request while a run is active.
- busy, output, 1: high in RUN.
- done, output, 1: high in DONE.
- cnt, output, WIDTH: current counter value, registered; bypassed positions always read 0.
- ovf, output, 1: one-cycle pulse marking the wrap step.
- steps, output, WIDTH+1: number of steps taken in the current or last run; saturates at all-ones.

## Operation
- FSM states are IDLE, RUN and DONE. Reset puts it in IDLE.
- Reset values: busy=0, done=0, cnt=0, ovf=0, steps=0, internal mask=0.
- IDLE or DONE with start=1:
  - mask ← bp, cnt ← 0, steps ← 0, state ← RUN.
  - done drops and busy rises on the same edge.
- start during RUN is ignored; the mask stays unchanged.
- RUN with halt=1:
  - state ← DONE.
  - No step is taken in that cycle, even if en=1. halt has priority over en.
- RUN with halt=0 and en=1 takes one step:
  - sum = (cnt | mask) + 1, computed WIDTH+1 bits wide.
  - cnt ← sum[WIDTH−1:0] & ~mask.
  - wrap = sum[WIDTH]. This happens exactly when every active bit of cnt is 1, or when mask is all ones.
  - steps ← steps + 1 (saturating).
  - ovf ← wrap.
  - If wrap and AUTO_STOP=1: state ← DONE.
- RUN with halt=0 and en=0: all state holds; ovf ← 0.
- In DONE, cnt and steps hold their last values until the next accepted start.
- Period is 2^(WIDTH−popcount(mask)) steps.
  - mask all ones: period 1. Every step wraps, cnt stays 0, ovf pulses on every step.
  - mask=0: plain binary counter with period 2^WIDTH.
- REVERSE affects only the `cnt` output mapping. Internal counting and the wrap test are unchanged.

## Timing
- All outputs are registered; there is no combinational path from input to output.
- start accepted at edge k: busy=1 and cnt=0 visible after edge k. The first step can occur at edge k+1 with en=1.
- Step latency is 1 cycle: en sampled at edge k gives the new cnt, steps and ovf after edge k.
- ovf is high for exactly the cycle following the wrap edge, coincident with cnt=0.
- With AUTO_STOP=1, done rises on the wrap edge itself, together with ovf.
- halt sampled at edge k gives done=1 and busy=0 after edge k. cnt and steps are unchanged.
- start and halt together in RUN: halt wins and start is ignored.
- start and en together in IDLE or DONE: start is taken and en is ignored.
- Asserting rst_n low at any time, mid-run included:
  - All outputs go to their reset values immediately, without waiting for clk.
  - The mask clears.
  - The FSM returns to IDLE.
- steps saturates at 2^(WIDTH+1)−1 (only reachable with AUTO_STOP=0) and never wraps.

## Test plan
All scenarios use WIDTH=4.
- **Full period.** AUTO_STOP=1, REVERSE=0, bp=0000, start, then en held high. Required: cnt runs 1,2,…,15,0; ovf pulses together with cnt=0 after the 16th step; done=1; steps=16.
- **Partial mask.** bp=0101, en held high. Required: cnt sequence 0000→0010→1000→1010→0000; ovf and done on step 4; steps=4.
- **All bits bypassed.** bp=1111. Required: after step 1, cnt=0, ovf=1, done=1, steps=1.
- **Early halt.** bp=0000, 5 en pulses, then halt with en=1. Required: done=1 with cnt=0101, steps=5, and ovf never asserted. A start issued in the same cycle as halt during the run is ignored.
- **Reverse, free-running, reset.** REVERSE=1, AUTO_STOP=0, bp=0000. Required: cnt output 0000,1000,0100,1100,…; after the wrap, ovf pulses but busy stays 1. Drop rst_n mid-run: all outputs read 0 before the next clk edge.
